// File: rtl/echo_pkg.sv
// Shared definitions for the echo indication path: serializer FSM encoding
// and the header field layout used on the host-side indication portal.
package echo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } echo_state_e;

    localparam int ECHO_BEATS_PER_MSG = 3;
    localparam int ECHO_METHOD_ID_W   = 8;
    localparam int ECHO_SEQ_W         = 8;

    localparam logic [ECHO_METHOD_ID_W-1:0] ECHO_DEFAULT_METHOD_ID = 8'h01;

endpackage

// File: rtl/echo_indication_serializer.sv
// Turns each 32-bit ind$heard indication into a 3-beat 16-bit message
// (header, low half, high half) for the host indication portal.
module echo_indication_serializer
    import echo_pkg::*;
#(
    parameter logic [ECHO_METHOD_ID_W-1:0] METHOD_ID = ECHO_DEFAULT_METHOD_ID
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ind_heard__ENA,
    input  logic [31:0] ind_heard_v,
    output logic        ind_heard__RDY,
    output logic        out_beat__ENA,
    output logic [15:0] out_beat_data,
    output logic        out_beat_last,
    input  logic        out_beat__RDY,
    output logic [15:0] stall_count
);

    echo_state_e           state;
    echo_state_e           next_state;
    logic [31:0]           hold;
    logic [ECHO_SEQ_W-1:0] seq;
    logic [ECHO_SEQ_W-1:0] hdr_seq;
    logic                  in_xfer;
    logic                  out_xfer;

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    assign in_xfer  = ind_heard__ENA & ind_heard__RDY;
    assign out_xfer = out_beat__ENA & out_beat__RDY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_xfer)  next_state = ST_HDR;
            ST_HDR:  if (out_xfer) next_state = ST_LO;
            ST_LO:   if (out_xfer) next_state = ST_HI;
            ST_HI:   if (out_xfer) next_state = in_xfer ? ST_HDR : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Beat content is a pure decode of registers, so it cannot move while stalled.
    always_comb begin
        out_beat__ENA  = (state != ST_IDLE);
        out_beat_data  = 16'h0000;
        out_beat_last  = 1'b0;
        ind_heard__RDY = ~RST & ((state == ST_IDLE) |
                                 ((state == ST_HI) & out_beat__RDY));
        case (state)
            ST_HDR: out_beat_data = {METHOD_ID, hdr_seq};
            ST_LO:  out_beat_data = hold[15:0];
            ST_HI: begin
                out_beat_data = hold[31:16];
                out_beat_last = 1'b1;
            end
            default: out_beat_data = 16'h0000;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold    <= '0;
            seq     <= '0;
            hdr_seq <= '0;
        end else if (in_xfer) begin
            hold    <= ind_heard_v;
            hdr_seq <= seq;
            seq     <= seq + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count <= 16'h0000;
        end else if (out_beat__ENA & ~out_beat__RDY) begin
            stall_count <= sat_inc16(stall_count);
        end
    end

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Scoreboard bench for echo_indication_serializer: expected beats are queued
// when an indication is accepted and popped as the DUT emits beats.
module tb_echo_indication_serializer;

    localparam logic [7:0] MID = 8'h01;

    logic        clk;
    logic        rst;
    logic        ind_ena;
    logic [31:0] ind_v;
    logic        ind_rdy;
    logic        beat_ena;
    logic [15:0] beat_data;
    logic        beat_last;
    logic        beat_rdy;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [16:0] sb_q[$];
    int          beat_cyc_q[$];
    logic        beat_rdy_q[$];
    logic [15:0] beat_data_q[$];
    logic [7:0]  exp_seq;

    echo_indication_serializer #(.METHOD_ID(MID)) dut (
        .CLK            (clk),
        .RST            (rst),
        .ind_heard__ENA (ind_ena),
        .ind_heard_v    (ind_v),
        .ind_heard__RDY (ind_rdy),
        .out_beat__ENA  (beat_ena),
        .out_beat_data  (beat_data),
        .out_beat_last  (beat_last),
        .out_beat__RDY  (beat_rdy),
        .stall_count    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every accepted beat is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && beat_ena && beat_rdy) begin
            beat_cyc_q.push_back(cyc);
            beat_rdy_q.push_back(ind_rdy);
            beat_data_q.push_back(beat_data);
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = sb_q.pop_front();
                check_eq("beat_data", {16'h0, beat_data}, {16'h0, e[15:0]});
                check_eq("beat_last", {31'h0, beat_last}, {31'h0, e[16]});
            end
        end
    end

    task automatic clear_records();
        beat_cyc_q.delete();
        beat_rdy_q.delete();
        beat_data_q.delete();
    endtask

    task automatic push_msg(input logic [31:0] v);
        sb_q.push_back({1'b0, MID, exp_seq});
        sb_q.push_back({1'b0, v[15:0]});
        sb_q.push_back({1'b1, v[31:16]});
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ind_ena  = 1'b0;
        ind_v    = 32'h0;
        beat_rdy = 1'b1;
        sb_q.delete();
        exp_seq = 8'h00;
        clear_records();
        @(negedge clk);
        check_eq("rst_beat_ena", {31'h0, beat_ena}, 32'd0);
        check_eq("rst_data", {16'h0, beat_data}, 32'd0);
        check_eq("rst_last", {31'h0, beat_last}, 32'd0);
        check_eq("rst_stall", {16'h0, stall_cnt}, 32'd0);
        check_eq("rst_ind_rdy", {31'h0, ind_rdy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rdy_after_rst", {31'h0, ind_rdy}, 32'd1);
        @(posedge clk); #1;
    endtask

    // Called just after a rising edge; returns just after the edge that follows acceptance.
    task automatic offer(input logic [31:0] v, output int acc_cyc);
        bit done;
        done    = 0;
        acc_cyc = -1;
        ind_ena = 1'b1;
        ind_v   = v;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (ind_rdy) begin
                push_msg(v);
                acc_cyc = cyc;
                done    = 1;
            end
            @(posedge clk); #1;
        end
        ind_ena = 1'b0;
        if (!done) check_eq("offer_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !beat_ena) done = 1;
        end
        @(posedge clk); #1;
        if (!done) check_eq("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int dummy;

        // Single indication: beats land in cycles N+1..N+3.
        do_reset();
        offer(32'hDEADBEEF, n);
        @(negedge clk);
        check_eq("single_hdr_ena", {31'h0, beat_ena}, 32'd1);
        check_eq("single_hdr", {16'h0, beat_data}, 32'h0100);
        check_eq("single_hdr_last", {31'h0, beat_last}, 32'd0);
        @(negedge clk);
        check_eq("single_lo", {16'h0, beat_data}, 32'hBEEF);
        @(negedge clk);
        check_eq("single_hi", {16'h0, beat_data}, 32'hDEAD);
        check_eq("single_hi_last", {31'h0, beat_last}, 32'd1);
        @(negedge clk);
        check_eq("single_idle_ena", {31'h0, beat_ena}, 32'd0);
        @(posedge clk); #1;
        drain();

        // Back-to-back messages with no idle gap.
        do_reset();
        offer(32'd1, dummy);
        offer(32'd2, dummy);
        offer(32'd3, dummy);
        drain();
        check_eq("b2b_beats", beat_cyc_q.size(), 32'd9);
        if (beat_cyc_q.size() == 9) begin
            check_eq("b2b_span", beat_cyc_q[8] - beat_cyc_q[0], 32'd8);
            for (int i = 0; i < 9; i++)
                check_eq($sformatf("b2b_rdy%0d", i), {31'h0, beat_rdy_q[i]},
                         (i % 3 == 2) ? 32'd1 : 32'd0);
            check_eq("b2b_hdr0", {16'h0, beat_data_q[0]}, 32'h0100);
            check_eq("b2b_hdr1", {16'h0, beat_data_q[3]}, 32'h0101);
            check_eq("b2b_hdr2", {16'h0, beat_data_q[6]}, 32'h0102);
        end

        // Back-pressure during the low-half beat.
        do_reset();
        offer(32'h12345678, n);
        @(posedge clk); #1;
        beat_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bp_hold_ena", {31'h0, beat_ena}, 32'd1);
            check_eq("bp_hold_data", {16'h0, beat_data}, 32'h5678);
            @(posedge clk); #1;
        end
        beat_rdy = 1'b1;
        drain();
        check_eq("bp_stall", {16'h0, stall_cnt}, 32'd4);
        check_eq("bp_beats", beat_cyc_q.size(), 32'd3);
        if (beat_cyc_q.size() == 3) begin
            check_eq("bp_lo_cyc", beat_cyc_q[1] - n, 32'd6);
            check_eq("bp_hi_cyc", beat_cyc_q[2] - n, 32'd7);
        end

        // Sequence number wrap.
        do_reset();
        for (int i = 0; i < 257; i++) offer(32'hA5000000 + i, dummy);
        drain();
        check_eq("wrap_beats", beat_data_q.size(), 32'd771);
        if (beat_data_q.size() == 771) begin
            check_eq("wrap_hdr256", {16'h0, beat_data_q[765]}, 32'h01FF);
            check_eq("wrap_hdr257", {16'h0, beat_data_q[768]}, 32'h0100);
        end

        // Asynchronous reset in the middle of a message.
        do_reset();
        offer(32'hAABBCCDD, n);
        @(posedge clk); #1;
        check_eq("mid_in_lo", {16'h0, beat_data}, 32'hCCDD);
        #2;
        rst = 1'b1;
        sb_q.delete();
        exp_seq = 8'h00;
        clear_records();
        #1;
        check_eq("mid_rst_ena", {31'h0, beat_ena}, 32'd0);
        check_eq("mid_rst_data", {16'h0, beat_data}, 32'd0);
        check_eq("mid_rst_last", {31'h0, beat_last}, 32'd0);
        check_eq("mid_rst_rdy", {31'h0, ind_rdy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rdy_after", {31'h0, ind_rdy}, 32'd1);
        @(posedge clk); #1;
        offer(32'h01020304, dummy);
        drain();
        check_eq("mid_beats", beat_data_q.size(), 32'd3);
        if (beat_data_q.size() == 3)
            check_eq("mid_next_hdr", {16'h0, beat_data_q[0]}, 32'h0100);

        // Stall counter saturation; ENA while not ready must be ignored.
        do_reset();
        beat_rdy = 1'b0;
        offer(32'h0BADF00D, dummy);
        ind_ena = 1'b1;
        ind_v   = 32'h55555555;
        repeat (70000) begin
            @(posedge clk); #1;
        end
        check_eq("sat_stall", {16'h0, stall_cnt}, 32'hFFFF);
        check_eq("sat_ind_rdy", {31'h0, ind_rdy}, 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check_eq("sat_stall_hold", {16'h0, stall_cnt}, 32'hFFFF);
        ind_ena  = 1'b0;
        beat_rdy = 1'b1;
        drain();
        check_eq("sat_stall_after", {16'h0, stall_cnt}, 32'hFFFF);
        offer(32'h11112222, dummy);
        drain();
        check_eq("sat_beats", beat_data_q.size(), 32'd6);
        if (beat_data_q.size() == 6)
            check_eq("sat_next_hdr", {16'h0, beat_data_q[3]}, 32'h0101);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
